onchip_mem_arbiter: RTL and testbench

- Two-requester Avalon-MM arbiter in front of the 5120x32 single-port on-chip RAM (13-bit word address, 4-bit byteenable, registered address, unregistered q).
- Arbitrates each cycle, round-robin on contention, and drives the RAM slave port.
- Returns read data with per-requester readdatavalid, and blocks and counts out-of-range accesses.
- Sits between the CPU data master (m0) and a DMA/peripheral master (m1) and the RAM.

---
 rtl/onchip_mem_pkg.sv | 18 +
 rtl/onchip_mem_arbiter_if.sv | 27 ++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/onchip_mem_arbiter.sv | 104 ++++++++++
 tb/tb_onchip_mem_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared constants and command type for the on-chip RAM arbiter slice.
// Describes the 5120x32 single-port RAM with 13-bit word addressing.
package onchip_mem_pkg;

   localparam int MEM_ADDR_W = 13;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_BE_W   = MEM_DATA_W / 8;
   localparam int MEM_DEPTH  = 5120;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] address;
      logic [MEM_BE_W-1:0]   byteenable;
      logic                  read;
      logic                  write;
      logic [MEM_DATA_W-1:0] writedata;
   } mem_cmd_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM requester port bundle: the master drives the command and the
// slave (the arbiter) answers with waitrequest and read return.
interface onchip_mem_arbiter_if #(
   parameter int ADDR_W = onchip_mem_pkg::MEM_ADDR_W,
   parameter int DATA_W = onchip_mem_pkg::MEM_DATA_W
);

   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a combinational same-cycle grant.
// last_grant remembers the most recent accepted winner; m0 wins the first tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last_grant;

   // NOTE: grant gets a full default first so no path through this block leaves it unassigned (no latch).
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-requester arbiter in front of the single-port on-chip RAM: grants one
// command per cycle, returns reads with fixed 1-cycle latency, blocks and counts out-of-range accesses.
module onchip_mem_arbiter #(
   parameter int ADDR_W    = onchip_mem_pkg::MEM_ADDR_W,
   parameter int DATA_W    = onchip_mem_pkg::MEM_DATA_W,
   parameter int MEM_DEPTH = onchip_mem_pkg::MEM_DEPTH,
   parameter int ERR_W     = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   onchip_mem_arbiter_if.slave m0,
   onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,
   output logic [ERR_W-1:0]    oob_count
);

   import onchip_mem_pkg::mem_cmd_t;

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

   mem_cmd_t   m0_cmd;
   mem_cmd_t   m1_cmd;
   mem_cmd_t   sel_cmd;
   logic [1:0] req_raw;
   logic [1:0] req;
   logic [1:0] grant;
   logic       grant_any;
   logic       in_range;
   logic       accept_rd;
   logic       rd_pend;
   logic       rd_owner;
   logic       rd_oob;

   always_comb begin
      m0_cmd.address    = m0.address;
      m0_cmd.byteenable = m0.byteenable;
      m0_cmd.read       = m0.read;
      m0_cmd.write      = m0.write;
      m0_cmd.writedata  = m0.writedata;
      m1_cmd.address    = m1.address;
      m1_cmd.byteenable = m1.byteenable;
      m1_cmd.read       = m1.read;
      m1_cmd.write      = m1.write;
      m1_cmd.writedata  = m1.writedata;
   end

   // Requests are masked in reset so the RAM is never touched while reset_n is low.
   assign req_raw = {m1.read | m1.write, m0.read | m0.write};
   assign req     = req_raw & {2{reset_n}};

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .accept  (grant_any),
      .grant   (grant)
   );

   assign grant_any = |grant;
   assign sel_cmd   = grant[1] ? m1_cmd : m0_cmd;
   assign in_range  = {1'b0, sel_cmd.address} < DEPTH_LIM;
   assign accept_rd = grant_any & sel_cmd.read & ~sel_cmd.write;

   assign mem_address    = sel_cmd.address;
   assign mem_byteenable = sel_cmd.byteenable;
   assign mem_writedata  = sel_cmd.writedata;
   assign mem_chipselect = grant_any & in_range;
   assign mem_write      = mem_chipselect & sel_cmd.write;
   assign mem_clken      = 1'b1;

   // Only a requester that is actually losing stalls; an idle one sees 0.
   assign m0.waitrequest = ~reset_n | (req_raw[0] & ~grant[0]);
   assign m1.waitrequest = ~reset_n | (req_raw[1] & ~grant[1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend   <= 1'b0;
         rd_owner  <= 1'b0;
         rd_oob    <= 1'b0;
         oob_count <= '0;
      end else begin
         rd_pend <= accept_rd;
         if (accept_rd) begin
            rd_owner <= grant[1];
            rd_oob   <= ~in_range;
         end
         if (grant_any && !in_range && (oob_count != {ERR_W{1'b1}})) begin
            oob_count <= oob_count + ERR_W'(1);
         end
      end
   end

   assign m0.readdatavalid = rd_pend & ~rd_owner;
   assign m1.readdatavalid = rd_pend & rd_owner;
   assign m0.readdata      = rd_oob ? '0 : mem_readdata;
   assign m1.readdata      = rd_oob ? '0 : mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter with a behavioural RAM
// (registered address, unregistered q), a shadow memory model and a read scoreboard.
module tb_onchip_mem_arbiter;

   localparam int AW    = 13;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 5120;
   localparam int ERR_W = 16;

   typedef struct {
      bit          owner;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
   onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

   logic [AW-1:0]    mem_address;
   logic [BW-1:0]    mem_byteenable;
   logic             mem_chipselect;
   logic             mem_write;
   logic [DW-1:0]    mem_writedata;
   logic             mem_clken;
   logic [DW-1:0]    mem_readdata;
   logic [ERR_W-1:0] oob_count;

   onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .m0             (m0_if),
      .m1             (m1_if),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .oob_count      (oob_count)
   );

   // Behavioural single-port RAM.
   logic [DW-1:0] ram [0:DEPTH-1];
   logic [AW-1:0] ram_addr_q;
   int            ram_wr_cnt;

   initial begin
      ram_wr_cnt = 0;
      for (int i = 0; i < DEPTH; i++) ram[i] = '0;
   end

   always @(posedge clk) begin
      if (mem_clken === 1'b1) begin
         ram_addr_q <= mem_address;
         if (mem_chipselect === 1'b1 && mem_write === 1'b1 && int'(mem_address) < DEPTH) begin
            ram_wr_cnt = ram_wr_cnt + 1;
            for (int b = 0; b < BW; b++) begin
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
            end
         end
      end
   end

   assign mem_readdata = (int'(ram_addr_q) < DEPTH) ? ram[ram_addr_q] : '0;

   int          total = 0;
   int          bad   = 0;
   exp_t        sb[$];
   logic [31:0] shadow [int];
   bit          exp_last = 1'b1;
   int          exp_oob  = 0;

   // Read-return monitor: every readdatavalid must match the oldest expectation.
   exp_t        mon_e;
   bit          mon_ow;
   logic [31:0] mon_d;
   always @(negedge clk) begin
      if (m0_if.readdatavalid === 1'b1 || m1_if.readdatavalid === 1'b1) begin
         total++;
         mon_ow = (m1_if.readdatavalid === 1'b1);
         mon_d  = mon_ow ? m1_if.readdata : m0_if.readdata;
         if (m0_if.readdatavalid === 1'b1 && m1_if.readdatavalid === 1'b1) begin
            bad++;
            $display("FAIL rdvalid_both: m0=1 m1=1, required only one owner");
         end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL rdvalid_unexpected: m%0d valid data=%h, required no valid", mon_ow, mon_d);
         end else begin
            mon_e = sb.pop_front();
            if (mon_ow !== mon_e.owner || mon_d !== mon_e.data) begin
               bad++;
               $display("FAIL rd_return: got m%0d data=%h, required m%0d data=%h",
                        mon_ow, mon_d, mon_e.owner, mon_e.data);
            end
         end
      end
   end

   task automatic drive(input bit m, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] d);
      if (!m) begin
         m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
         m0_if.byteenable = be; m0_if.writedata = d;
      end else begin
         m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
         m1_if.byteenable = be; m1_if.writedata = d;
      end
   endtask

   function automatic logic wait_of(input bit m);
      return m ? m1_if.waitrequest : m0_if.waitrequest;
   endfunction

   function automatic logic valid_of(input bit m);
      return m ? m1_if.readdatavalid : m0_if.readdatavalid;
   endfunction

   function automatic void model_write(input logic [AW-1:0] a, input logic [BW-1:0] be,
                                       input logic [DW-1:0] d);
      logic [31:0] w;
      w = shadow.exists(int'(a)) ? shadow[int'(a)] : 32'h0;
      for (int b = 0; b < BW; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      shadow[int'(a)] = w;
   endfunction

   function automatic logic [31:0] model_read(input logic [AW-1:0] a);
      if (int'(a) >= DEPTH) return 32'h0;
      return shadow.exists(int'(a)) ? shadow[int'(a)] : 32'h0;
   endfunction

   function automatic void push_exp(input bit m, input logic [31:0] d);
      exp_t e;
      e.owner = m;
      e.data  = d;
      sb.push_back(e);
   endfunction

   // One command from one requester while the other is idle.
   task automatic single_cmd(input bit m, input bit rd, input bit wr, input logic [AW-1:0] a,
                             input logic [BW-1:0] be, input logic [DW-1:0] d);
      bit oob = (int'(a) >= DEPTH);
      bit got = 1'b0;
      @(posedge clk); #1;
      drive(m, rd, wr, a, be, d);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wait_of(m) === 1'b0) begin
            got = 1'b1;
            break;
         end
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL accept_timeout: m%0d waitrequest stuck at 1, required 0", m);
         drive(m, 1'b0, 1'b0, '0, '0, '0);
         return;
      end
      total++;
      if (mem_chipselect !== !oob || mem_write !== (wr && !oob)) begin
         bad++;
         $display("FAIL mem_drive: chipselect=%b write=%b, required chipselect=%b write=%b",
                  mem_chipselect, mem_write, !oob, (wr && !oob));
      end
      if (wr) begin
         if (!oob) model_write(a, be, d);
      end else if (rd) begin
         push_exp(m, model_read(a));
      end
      if (oob && exp_oob < 65535) exp_oob++;
      exp_last = m;
      @(posedge clk); #1;
      drive(m, 1'b0, 1'b0, '0, '0, '0);
      total++;
      if (oob_count !== ERR_W'(exp_oob)) begin
         bad++;
         $display("FAIL oob_count: got %0d, required %0d", oob_count, exp_oob);
      end
      if (rd && !wr) begin
         @(negedge clk);
         total++;
         if (valid_of(m) !== 1'b1 || valid_of(!m) !== 1'b0) begin
            bad++;
            $display("FAIL read_latency: m%0d valid=%b other=%b, required 1 and 0",
                     m, valid_of(m), valid_of(!m));
         end
      end
   endtask

   // Both requesters read continuously; the winner must alternate.
   task automatic contention(input int cycles, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      bit w;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, a0, 4'hF, '0);
      drive(1'b1, 1'b1, 1'b0, a1, 4'hF, '0);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         w = ~exp_last;
         total++;
         if (wait_of(w) !== 1'b0 || wait_of(!w) !== 1'b1) begin
            bad++;
            $display("FAIL contention_grant: cycle %0d wait m0=%b m1=%b, required winner m%0d",
                     i, m0_if.waitrequest, m1_if.waitrequest, w);
         end
         push_exp(w, model_read(w ? a1 : a0));
         exp_last = w;
         @(posedge clk);
      end
      #1;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic drain(input string name);
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: %0d reads outstanding, required 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b1, 1'b0, 13'h0005, 4'hF, '0);
      drive(1'b1, 1'b0, 1'b1, 13'h0006, 4'hF, 32'h55AA55AA);
      repeat (2) @(negedge clk);
      total++;
      if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1 || mem_chipselect !== 1'b0 ||
          m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0 || oob_count !== '0) begin
         bad++;
         $display("FAIL reset_state: wait=%b%b cs=%b valid=%b%b oob=%0d, required 11 0 00 0",
                  m0_if.waitrequest, m1_if.waitrequest, mem_chipselect,
                  m0_if.readdatavalid, m1_if.readdatavalid, oob_count);
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b0) begin
         bad++;
         $display("FAIL idle_wait: m0=%b m1=%b, required 0 0", m0_if.waitrequest, m1_if.waitrequest);
      end
   endtask

   task automatic test_write_read();
      single_cmd(1'b0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hA5A5A5A5);
      single_cmd(1'b0, 1'b1, 1'b0, 13'h0010, 4'hF, '0);
      drain("write_read");
   endtask

   task automatic test_byte_lanes();
      single_cmd(1'b0, 1'b0, 1'b1, 13'h0100, 4'hF, 32'h11223344);
      single_cmd(1'b1, 1'b0, 1'b1, 13'h0100, 4'h5, 32'hFFFFFFFF);
      single_cmd(1'b1, 1'b1, 1'b0, 13'h0100, 4'hF, '0);
      drain("byte_lanes");
   endtask

   task automatic test_contention();
      single_cmd(1'b0, 1'b0, 1'b1, 13'h0001, 4'hF, 32'hC0DE0001);
      single_cmd(1'b1, 1'b0, 1'b1, 13'h0002, 4'hF, 32'hC0DE0002);
      contention(6, 13'h0001, 13'h0002);
      drain("contention");
   endtask

   task automatic test_oob();
      int wr_before = ram_wr_cnt;
      single_cmd(1'b0, 1'b0, 1'b1, 13'h1400, 4'hF, 32'hDEADBEEF);
      single_cmd(1'b0, 1'b1, 1'b0, 13'h1400, 4'hF, '0);
      drain("oob");
      total++;
      if (oob_count !== 16'd2 || ram_wr_cnt != wr_before) begin
         bad++;
         $display("FAIL oob_block: count=%0d ram_writes=%0d, required 2 and %0d",
                  oob_count, ram_wr_cnt, wr_before);
      end
   endtask

   task automatic test_oob_saturate();
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 13'h1FFF, 4'hF, 32'h0BAD0BAD);
      repeat (100) @(posedge clk);
      exp_oob = exp_oob + 100;
      @(negedge clk);
      total++;
      if (oob_count !== ERR_W'(exp_oob)) begin
         bad++;
         $display("FAIL oob_count_mid: got %0d, required %0d", oob_count, exp_oob);
      end
      repeat (65437) @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      exp_oob = 65535;
      exp_last = 1'b0;
      @(negedge clk);
      total++;
      if (oob_count !== 16'hFFFF) begin
         bad++;
         $display("FAIL oob_saturate: got %h, required ffff", oob_count);
      end
   endtask

   task automatic test_rw_both();
      single_cmd(1'b0, 1'b1, 1'b1, 13'h0020, 4'hF, 32'h12345678);
      single_cmd(1'b0, 1'b1, 1'b0, 13'h0020, 4'hF, '0);
      drain("rw_both");
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 13'h0030, 4'hF, 32'hCAFEF00D);
      @(negedge clk);
      total++;
      if (m0_if.waitrequest !== 1'b0 || mem_write !== 1'b1) begin
         bad++;
         $display("FAIL b2b_write: wait=%b mem_write=%b, required 0 1", m0_if.waitrequest, mem_write);
      end
      model_write(13'h0030, 4'hF, 32'hCAFEF00D);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 13'h0030, 4'hF, '0);
      @(negedge clk);
      total++;
      if (m0_if.waitrequest !== 1'b0) begin
         bad++;
         $display("FAIL b2b_read: wait=%b, required 0", m0_if.waitrequest);
      end
      push_exp(1'b0, model_read(13'h0030));
      exp_last = 1'b0;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drain("back_to_back");
   endtask

   task automatic test_reset_mid_read();
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 13'h0002, 4'hF, '0);
      @(negedge clk);
      total++;
      if (m1_if.waitrequest !== 1'b0) begin
         bad++;
         $display("FAIL mid_read_accept: m1 wait=%b, required 0", m1_if.waitrequest);
      end
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b0, 1'b1, 1'b0, 13'h0001, 4'hF, '0);
      reset_n = 1'b0;
      @(negedge clk);
      total++;
      if (m1_if.readdatavalid !== 1'b0 || m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset: m1 valid=%b wait=%b%b, required 0 11",
                  m1_if.readdatavalid, m0_if.waitrequest, m1_if.waitrequest);
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      exp_last = 1'b1;
      exp_oob = 0;
      total++;
      if (oob_count !== '0) begin
         bad++;
         $display("FAIL oob_after_reset: got %0d, required 0", oob_count);
      end
      contention(2, 13'h0001, 13'h0002);
      drain("reset_mid_read");
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_contention();
      test_oob();
      test_oob_saturate();
      test_rw_both();
      test_back_to_back();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
